// File: rtl/altera_emif_arch_nf_pll_phase_step_pkg.sv
// rtl/altera_emif_arch_nf_pll_phase_step_pkg.sv - state encoding and default timing for the IOPLL phase-step controller
package altera_emif_arch_nf_pll_phase_step_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        RESP    = 3'd5
    } step_state_e;

    localparam int DEF_STEP_CNT_W      = 8;
    localparam int DEF_PHASE_EN_CYCLES = 4;
    localparam int DEF_DONE_LO_WAIT    = 8;
    localparam int DEF_DONE_HI_TIMEOUT = 1024;

    // One shared cycle counter covers the pulse, done-low and done-high windows.
    function automatic int wait_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/altera_emif_arch_nf_pll_phase_step_sync.sv
// rtl/altera_emif_arch_nf_pll_phase_step_sync.sv - two-flop synchronizer, async reset to 0
module altera_emif_arch_nf_pll_phase_step_sync (
    input  logic cal_slave_clk_int,
    input  logic global_reset_n_int,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge cal_slave_clk_int or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/altera_emif_arch_nf_pll_phase_step_ctrl.sv
// rtl/altera_emif_arch_nf_pll_phase_step_ctrl.sv - issues N single-step phase_en pulses to the IOPLL per calibration request
module altera_emif_arch_nf_pll_phase_step_ctrl
    import altera_emif_arch_nf_pll_phase_step_pkg::*;
#(
    parameter int PORT_DFT_NF_PLL_CNTSEL_WIDTH    = 1,
    parameter int PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH = 1,
    parameter int STEP_CNT_W                      = DEF_STEP_CNT_W,
    parameter int PHASE_EN_CYCLES                 = DEF_PHASE_EN_CYCLES,
    parameter int DONE_LO_WAIT                    = DEF_DONE_LO_WAIT,
    parameter int DONE_HI_TIMEOUT                 = DEF_DONE_HI_TIMEOUT
) (
    input  logic                                       cal_slave_clk_int,
    input  logic                                       global_reset_n_int,
    input  logic                                       pll_locked,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [PORT_DFT_NF_PLL_CNTSEL_WIDTH-1:0]    req_cnt_sel,
    input  logic                                       req_up_dn,
    input  logic [STEP_CNT_W-1:0]                      req_num_steps,
    output logic                                       rsp_valid,
    output logic                                       rsp_error,
    output logic [STEP_CNT_W-1:0]                      rsp_steps_done,
    output logic                                       busy,
    output logic                                       pll_phase_en,
    output logic                                       pll_up_dn,
    output logic [PORT_DFT_NF_PLL_CNTSEL_WIDTH-1:0]    pll_cnt_sel,
    output logic [PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH-1:0] pll_num_phase_shifts,
    input  logic                                       pll_phase_done
);

    localparam int CNT_W = wait_cnt_width(PHASE_EN_CYCLES, DONE_LO_WAIT, DONE_HI_TIMEOUT);
    localparam logic [CNT_W-1:0] PE_LAST = CNT_W'(PHASE_EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(DONE_LO_WAIT - 1);
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(DONE_HI_TIMEOUT - 1);

    step_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STEP_CNT_W-1:0] steps_q, steps_d, steps_inc, num_q;
    logic                  err_q, err_d;
    logic                  step_done, accept, lock_s, done_s;

    altera_emif_arch_nf_pll_phase_step_sync u_lock_sync (
        .cal_slave_clk_int  (cal_slave_clk_int),
        .global_reset_n_int (global_reset_n_int),
        .din                (pll_locked),
        .dout               (lock_s)
    );

    altera_emif_arch_nf_pll_phase_step_sync u_done_sync (
        .cal_slave_clk_int  (cal_slave_clk_int),
        .global_reset_n_int (global_reset_n_int),
        .din                (pll_phase_done),
        .dout               (done_s)
    );

    assign accept    = req_valid && req_ready;
    assign steps_inc = steps_q + STEP_CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        steps_d   = steps_q;
        err_d     = err_q;
        step_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    steps_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (req_num_steps == '0) ? RESP : SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == PE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A PLL whose done never falls (fast-sim) is treated as having completed the step.
            WAIT_LO: begin
                if (!done_s) begin
                    cnt_d   = '0;
                    state_d = WAIT_HI;
                end else if (cnt_q == LO_LAST) begin
                    step_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (done_s) begin
                    step_done = 1'b1;
                end else if (cnt_q == HI_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (step_done) begin
            steps_d = steps_inc;
            state_d = (steps_inc == num_q) ? RESP : SETUP;
        end
        // Lock loss overrides any step completion seen on the same edge.
        if (!lock_s && state_q != IDLE && state_q != RESP) begin
            steps_d = steps_q;
            err_d   = 1'b1;
            state_d = RESP;
        end
    end

    always_ff @(posedge cal_slave_clk_int or negedge global_reset_n_int) begin
        if (!global_reset_n_int) begin
            state_q              <= IDLE;
            cnt_q                <= '0;
            steps_q              <= '0;
            num_q                <= '0;
            err_q                <= 1'b0;
            req_ready            <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_error            <= 1'b0;
            rsp_steps_done       <= '0;
            busy                 <= 1'b0;
            pll_phase_en         <= 1'b0;
            pll_up_dn            <= 1'b0;
            pll_cnt_sel          <= '0;
            pll_num_phase_shifts <= PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH'(1);
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            steps_q              <= steps_d;
            err_q                <= err_d;
            req_ready            <= (state_d == IDLE) && lock_s;
            busy                 <= (state_d != IDLE);
            pll_phase_en         <= (state_q == PULSE) && lock_s;
            rsp_valid            <= (state_q == RESP);
            rsp_error            <= (state_q == RESP) && err_q;
            rsp_steps_done       <= (state_q == RESP) ? steps_q : '0;
            pll_num_phase_shifts <= PORT_DFT_NF_PLL_NUM_SHIFT_WIDTH'(1);
            if (accept) begin
                num_q       <= req_num_steps;
                pll_cnt_sel <= req_cnt_sel;
                pll_up_dn   <= req_up_dn;
            end
        end
    end

endmodule
